// File: rtl/common_pkg.sv
// Shared SPI definitions: mode encoding, default widths and the core FSM states.
package common_pkg;

  localparam int DATA_WIDTH              = 8;
  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

  // Mode number is {CPOL, CPHA}
  typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} spi_mode_t;

  typedef enum logic {IDLE, ACTIVE} spi_state_t;

  function automatic logic spi_cpol(spi_mode_t m);
    return m[1];
  endfunction

  function automatic logic spi_cpha(spi_mode_t m);
    return m[0];
  endfunction

endpackage

// File: rtl/sync2edge.sv
// One-pin synchronizer chain followed by a registered edge detector.
// RESET_VAL presets the chain to the pin's idle level so reset release
// never looks like an edge.
module sync2edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Synchronize the pin and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_sync_core.sv
// clk_i-domain SPI peripheral core: oversampled pins, all four SPI modes,
// configurable width and bit order, tx valid/ready, rx strobe, tx underrun.
// Optional macro SPI_SYNC_RX_HANDSHAKE_EN turns rx_valid_o into a level
// cleared by rx_ack_i and adds the rx_overrun_o port.
module spi_sync_core
  import common_pkg::*;
#(
  parameter int DATA_WIDTH  = common_pkg::DATA_WIDTH,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = '1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  spi_cs_ni,
  input  logic                  spi_sck_i,
  input  logic                  spi_sd_i,
  output logic                  spi_sd_o,
  output logic                  spi_sd_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ack_i,
`ifdef SPI_SYNC_RX_HANDSHAKE_EN
  output logic                  rx_overrun_o,
`endif
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int              CW      = $clog2(DATA_WIDTH);
  localparam int              OUT_BIT = (MSB_FIRST != 0) ? DATA_WIDTH-1 : 0;
  localparam logic [CW-1:0]   LAST    = CW'(DATA_WIDTH-1);

  logic cs_rise, cs_fall, sck_rise, sck_fall, sdi;
  logic cs_unused, sck_unused, sdi_rise_unused, sdi_fall_unused;

  sync2edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk_i), .rst(reset_i), .din(spi_cs_ni),
    .sync(cs_unused), .rise(cs_rise), .fall(cs_fall));

  sync2edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'(CPOL))) u_sck (
    .clk(clk_i), .rst(reset_i), .din(spi_sck_i),
    .sync(sck_unused), .rise(sck_rise), .fall(sck_fall));

  sync2edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi (
    .clk(clk_i), .rst(reset_i), .din(spi_sd_i),
    .sync(sdi), .rise(sdi_rise_unused), .fall(sdi_fall_unused));

  // Leading edge leaves the idle level; CPHA picks which edge samples
  logic lead, trail, smp_edge, shf_edge;
  assign lead     = (CPOL != 0) ? sck_fall : sck_rise;
  assign trail    = (CPOL != 0) ? sck_rise : sck_fall;
  assign smp_edge = (CPHA != 0) ? trail : lead;
  assign shf_edge = (CPHA != 0) ? lead  : trail;

  spi_state_t state, state_nxt;
  logic       active, start_ld, do_smp, do_shf;
  logic       word_done, load;

  logic [DATA_WIDTH-1:0] tx_sr, tx_shf, rx_sr, rx_nxt;
  logic [CW-1:0]         bit_cnt;
  logic                  skip;

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state: CS fall opens a transfer, CS rise always closes it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = ACTIVE;
      ACTIVE:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: SCK edges only count while active, and CS rise beats a sample
  always_comb begin
    active   = 1'b0;
    start_ld = 1'b0;
    do_smp   = 1'b0;
    do_shf   = 1'b0;
    case (state)
      IDLE:    start_ld = cs_fall;
      ACTIVE: begin
        active = 1'b1;
        do_smp = smp_edge & ~cs_rise;
        do_shf = shf_edge & ~cs_rise;
      end
      default: ;
    endcase
  end

  assign word_done = do_smp && (bit_cnt == LAST);
  assign load      = start_ld | word_done;

  // Shift/insert direction follows the bit order for both registers
  always_comb begin
    if (MSB_FIRST != 0) begin
      tx_shf = {tx_sr[DATA_WIDTH-2:0], 1'b0};
      rx_nxt = {rx_sr[DATA_WIDTH-2:0], sdi};
    end else begin
      tx_shf = {1'b0, tx_sr[DATA_WIDTH-1:1]};
      rx_nxt = {sdi, rx_sr[DATA_WIDTH-1:1]};
    end
  end

  // Transmit shifter; skip holds the first bit of a fresh word across one shift edge
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_sr <= '0;
      skip  <= 1'b0;
    end else if (load) begin
      tx_sr <= tx_valid_i ? tx_data_i : TX_IDLE_WORD;
      skip  <= start_ld ? (CPHA != 0) : 1'b1;
    end else if (do_shf) begin
      if (skip) skip  <= 1'b0;
      else      tx_sr <= tx_shf;
    end
  end

  // Receive shifter and bit counter; a partial word dies with CS
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_sr     <= '0;
      rx_data_o <= '0;
      bit_cnt   <= '0;
    end else if (cs_rise || start_ld) begin
      bit_cnt <= '0;
    end else if (do_smp) begin
      rx_sr <= rx_nxt;
      if (word_done) begin
        rx_data_o <= rx_nxt;
        bit_cnt   <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef SPI_SYNC_RX_HANDSHAKE_EN
  // Level valid held until acked; completion wins over a coincident ack
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else if (word_done) begin
      rx_valid_o   <= 1'b1;
      rx_overrun_o <= rx_valid_o & ~rx_ack_i;
    end else begin
      rx_overrun_o <= 1'b0;
      if (rx_ack_i) rx_valid_o <= 1'b0;
    end
  end
`else
  logic ack_unused;
  assign ack_unused = rx_ack_i;

  // One-clk strobe per completed word
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rx_valid_o <= 1'b0;
    else         rx_valid_o <= word_done;
  end
`endif

  assign tx_ready_o    = load & tx_valid_i;
  assign tx_underrun_o = load & ~tx_valid_i;
  assign spi_sd_o      = tx_sr[OUT_BIT];
  assign spi_sd_oe_o   = active;
  assign busy_o        = active;

endmodule

// File: doc/spi_sync_core.md
Name: spi_sync_core

Overview:
- System-clock-synchronous SPI peripheral core. It oversamples the raw SPI pins in the clk_i domain and supports all four SPI modes and configurable word width and bit order.
- It is the successor to the SCK-clocked Mode-0 core. The Wishbone bridge and register file consume it directly, so no CDC is needed in those blocks.
- It provides a valid/ready transmit handshake, an rx strobe and a tx underrun flag.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (>=2).
- CPOL, 0, SCK idle level.
- CPHA, 0, 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- MSB_FIRST, 1, 1 = MSB first; 0 = LSB first (applies to both tx and rx).
- SYNC_STAGES, 2, flip-flops in each input synchronizer (>=2).
- TX_IDLE_WORD, '1, word transmitted on underrun.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  asynchronous, active-high reset.
- spi_cs_ni  input  1  chip select, active low, asynchronous to clk_i.
- spi_sck_i  input  1  serial clock, asynchronous to clk_i.
- spi_sd_i  input  1  SDI.
- spi_sd_o  output  1  SDO.
- spi_sd_oe_o  output  1  SDO output enable; high while CS is asserted (synchronized).
- tx_data_i  input  DATA_WIDTH  next word to transmit.
- tx_valid_i  input  1  tx_data_i is valid.
- tx_ready_o  output  1  one-clk pulse; the word was loaded this cycle.
- rx_data_o  output  DATA_WIDTH  last received word; held until the next word completes.
- rx_valid_o  output  1  received-word strobe (see Optional Feature).
- rx_ack_i  input  1  rx acknowledge; used only with the Optional Feature.
- tx_underrun_o  output  1  one-clk pulse; a load occurred while tx_valid_i was low.
- busy_o  output  1  CS asserted (synchronized).

Behaviour:
- Reset (async, reset_i=1): every output is 0; spi_sd_o=0, spi_sd_oe_o=0, rx_data_o=0. Synchronizers are preset to the idle levels (cs=1, sck=CPOL, sdi=0). FSM state = IDLE.
- Input path:
  - SYNC_STAGES synchronizer flops, then one registered edge-detect flop per pin.
  - A pin edge acts internally SYNC_STAGES+1 clk after it arrives.
  - SCK high and low phases must each be >= SYNC_STAGES+2 clk periods; faster SCK is unsupported.
- Leading edge = SCK leaving CPOL; trailing edge = SCK returning to CPOL.
  - sample_edge = leading if CPHA=0, else trailing.
  - shift_edge = the other edge.
- FSM state IDLE:
  - spi_sd_oe_o=0; SCK edges are ignored.
  - On the synchronized CS falling edge: load tx, bit_cnt=0, go to ACTIVE.
- Load operation (one clk):
  - tx_sr = tx_valid_i ? tx_data_i : TX_IDLE_WORD.
  - tx_ready_o=1 if tx_valid_i, else tx_underrun_o=1.
  - skip flag = CPHA for the CS-start load; skip flag = 1 for a mid-transfer reload.
- spi_sd_o = tx_sr[MSB_FIRST ? DATA_WIDTH-1 : 0], registered, valid while ACTIVE.
- FSM state ACTIVE, on shift_edge:
  - If skip=1, clear skip and do not shift.
  - Otherwise shift tx_sr one position toward the output bit.
- FSM state ACTIVE, on sample_edge:
  - Shift sdi into rx_sr: MSB_FIRST ? into bit 0, shifting left : into bit DATA_WIDTH-1, shifting right.
  - bit_cnt++ (width $clog2(DATA_WIDTH)).
  - If bit_cnt == DATA_WIDTH-1:
    - rx_data_o = completed word, including this bit.
    - Pulse rx_valid_o.
    - bit_cnt = 0.
    - Perform the load operation (reload) in the same clk.
- Back-to-back words continue with no gap and with CS held low.
- CS deassert (synchronized rising edge) in any state: go to IDLE next clk.
  - A partial word is discarded: no rx_valid_o, rx_data_o unchanged.
  - A consumed tx word is not re-offered.
  - spi_sd_oe_o=0; bit_cnt=0.
- Same-clk CS rising edge and sample_edge: CS wins; the sample is dropped.
- CS rises and falls again within one synchronizer window: this is a glitch and is not required to be detected.

Optional Feature:
- Macro: SPI_SYNC_RX_HANDSHAKE_EN.
- Defined:
  - rx_valid_o is a level signal. It is set on word completion and cleared on clk when rx_ack_i=1.
  - Adds output rx_overrun_o: one-clk pulse when a word completes while rx_valid_o=1.
  - In that case rx_data_o is overwritten with the newer word and rx_valid_o stays 1.
  - If ack and completion coincide, completion wins: rx_valid_o stays 1 and there is no overrun.
- Undefined: rx_valid_o is a one-clk strobe; rx_ack_i is ignored; no rx_overrun_o port.

Decomposition:
- common_pkg gains:
  - spi_mode_t enum (MODE0..MODE3) plus helpers spi_cpol() and spi_cpha().
  - SPI_SYNC_STAGES_DEFAULT constant.
  - DATA_WIDTH continues to come from common_pkg.
- Sub-module sync2edge: one synchronizer chain plus rise/fall detect. It has parameters STAGES and RESET_VAL and is instantiated for cs, sck and sdi (rise/fall unused on sdi).

Test Plan:
- Mode 0, 8-bit, MSB first, clk=50 MHz, SCK=2 MHz, tx_data_i=0xA5, SDI=0x3C -> SDO bits 1,0,1,0,0,1,0,1; rx_valid_o pulses once; rx_data_o=0x3C; tx_ready_o pulses once at CS fall.
- Modes 1, 2, 3 with the same data -> each yields rx_data_o=0x3C and SDO=0xA5, with correct bit alignment relative to the sample edges.
- MSB_FIRST=0, DATA_WIDTH=16, 0x1234 out and 0xBEEF in -> SDO LSB first; rx_data_o=0xBEEF.
- Three back-to-back words (0x11, 0x22, 0x33) with tx_valid_i low for the second word -> SDO 0x11, 0xFF, 0x33; tx_underrun_o pulses once; rx_valid_o pulses 3 times.
- CS raised after 5 bits -> no rx_valid_o; rx_data_o keeps its previous value; next transfer is correct from bit 0. reset_i asserted mid-word -> all outputs 0 immediately.
- With SPI_SYNC_RX_HANDSHAKE_EN: two words with no rx_ack_i -> rx_overrun_o pulses once, rx_data_o = second word; a single ack then clears rx_valid_o.
